// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared constants for the iterative multiply/divide unit: funct3 operation
//   encodings, FSM state encodings, iteration count and small operation
//   decode helpers used by both the datapath and the control FSM.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        INST_MUL    = 3'b000,
        INST_MULH   = 3'b001,
        INST_MULHSU = 3'b010,
        INST_MULHU  = 3'b011,
        INST_DIV    = 3'b100,
        INST_DIVU   = 3'b101,
        INST_REM    = 3'b110,
        INST_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

    localparam int unsigned MulDivCycles = 32;
    localparam logic [4:0]  LastCount    = 5'(MulDivCycles - 1);

    // Bit 2 of funct3 separates the divide family from the multiply family.
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic signed_a(input logic [2:0] op);
        logic res;
        case (op)
            INST_MULH, INST_MULHSU, INST_DIV, INST_REM: res = 1'b1;
            default:                                    res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic signed_b(input logic [2:0] op);
        logic res;
        case (op)
            INST_MULH, INST_DIV, INST_REM: res = 1'b1;
            default:                       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix
//   Two's-complement conditional negation. Used to turn signed operands into
//   magnitudes and to re-apply the sign to the final product/quotient/remainder.
// Ports:
//   value  - input word
//   negate - when high, output is -value, otherwise value passes through
//   fixed  - conditionally negated word
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] fixed
);

    assign fixed = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   RV32M multiply/divide unit. Division is restoring shift-subtract on operand
//   magnitudes, multiplication is shift-add into a 64-bit accumulator, one bit
//   per cycle for 32 cycles (34-cycle start-to-ready latency). Divide-by-zero
//   skips the iteration (2-cycle latency).
//   Optional build macro MULDIV_FAST_MUL_EN: multiply ops use a single-cycle
//   combinational product and also complete in 2 cycles.
// Ports:
//   clk, rst (async, active-low)
//   start_i, op_i[2:0], reg1_rdata_i[31:0], reg2_rdata_i[31:0], reg_waddr_i[4:0]
//   kill_i       - flush; returns to IDLE with no result
//   busy_o       - operation in flight
//   ready_o      - one-cycle result pulse; reg_we_o mirrors it
//   result_o, reg_waddr_o - valid with ready_o, zero otherwise
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] reg1_rdata_i,
    input  logic [31:0] reg2_rdata_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic [31:0] result_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o
);

    muldiv_state_e state_r;
    logic [4:0]    cnt_r;
    logic [2:0]    op_r;
    logic [31:0]   a_mag_r;
    logic [31:0]   b_mag_r;
    logic [63:0]   acc_r;
    logic          neg_r;
    logic          dbz_r;
    logic [4:0]    waddr_r;

    logic          sign_a_s;
    logic          sign_b_s;
    logic [31:0]   a_mag_s;
    logic [31:0]   b_mag_s;
    logic          dbz_s;
    logic          neg_s;
    logic [63:0]   mul_init_s;
    logic          mul_fast_s;
    logic [63:0]   acc_init_s;
    logic          to_done_s;
    logic [32:0]   div_diff_s;
    logic [32:0]   mul_sum_s;
    logic [63:0]   acc_step_s;
    logic [63:0]   res_sel_s;
    logic [63:0]   res_fix_s;
    logic [31:0]   final_s;

    assign sign_a_s = signed_a(op_i) & reg1_rdata_i[31];
    assign sign_b_s = signed_b(op_i) & reg2_rdata_i[31];
    assign dbz_s    = is_div_op(op_i) & (reg2_rdata_i == 32'd0);
    // Remainder follows the dividend; quotient and product follow A xor B.
    assign neg_s    = is_rem_op(op_i) ? sign_a_s : (sign_a_s ^ sign_b_s);

    muldiv_sign_fix #(.WIDTH(32)) u_fix_a (
        .value  (reg1_rdata_i),
        .negate (sign_a_s),
        .fixed  (a_mag_s)
    );

    muldiv_sign_fix #(.WIDTH(32)) u_fix_b (
        .value  (reg2_rdata_i),
        .negate (sign_b_s),
        .fixed  (b_mag_s)
    );

    // Accumulator preload and IDLE exit target for a newly accepted operation
    always_comb begin
        mul_init_s = 64'd0;
        mul_fast_s = 1'b0;
        acc_init_s = 64'd0;
        to_done_s  = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        mul_init_s = {32'd0, a_mag_s} * {32'd0, b_mag_s};
        mul_fast_s = 1'b1;
`else
        // Multiplier sits in the low half and is shifted out as the product grows.
        mul_init_s = {32'd0, b_mag_s};
        mul_fast_s = 1'b0;
`endif
        if (is_div_op(op_i)) begin
            // On divide-by-zero park |A| in the remainder half so REM yields A.
            acc_init_s = dbz_s ? {a_mag_s, 32'd0} : {32'd0, a_mag_s};
            to_done_s  = dbz_s;
        end else begin
            acc_init_s = mul_init_s;
            to_done_s  = mul_fast_s;
        end
    end

    // One iteration: acc = {remainder, quotient} for divide, {product_hi, multiplier} for multiply
    always_comb begin
        div_diff_s = acc_r[63:31] - {1'b0, b_mag_r};
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, a_mag_r} : 33'd0);
        acc_step_s = 64'd0;
        if (is_div_op(op_r)) begin
            // Negative trial difference means the divisor did not fit: restore.
            acc_step_s = div_diff_s[32] ? {acc_r[62:0], 1'b0}
                                        : {div_diff_s[31:0], acc_r[30:0], 1'b1};
        end else begin
            acc_step_s = {mul_sum_s, acc_r[31:1]};
        end
    end

    assign res_sel_s = !is_div_op(op_r) ? acc_r
                     : (is_rem_op(op_r) ? {32'd0, acc_r[63:32]} : {32'd0, acc_r[31:0]});

    muldiv_sign_fix #(.WIDTH(64)) u_fix_res (
        .value  (res_sel_s),
        .negate (neg_r),
        .fixed  (res_fix_s)
    );

    // Final result word selection per operation
    always_comb begin
        final_s = 32'd0;
        case (op_r)
            INST_MUL:                            final_s = res_fix_s[31:0];
            INST_MULH, INST_MULHSU, INST_MULHU:  final_s = res_fix_s[63:32];
            INST_DIV, INST_DIVU:                 final_s = dbz_r ? 32'hFFFF_FFFF : res_fix_s[31:0];
            INST_REM, INST_REMU:                 final_s = res_fix_s[31:0];
            default:                             final_s = 32'd0;
        endcase
    end

    // Control FSM, operand/accumulator registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            op_r        <= 3'd0;
            a_mag_r     <= 32'd0;
            b_mag_r     <= 32'd0;
            acc_r       <= 64'd0;
            neg_r       <= 1'b0;
            dbz_r       <= 1'b0;
            waddr_r     <= 5'd0;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
            reg_we_o    <= 1'b0;
            result_o    <= 32'd0;
            reg_waddr_o <= 5'd0;
        end else if (kill_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
            reg_we_o    <= 1'b0;
            result_o    <= 32'd0;
            reg_waddr_o <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_o     <= 1'b0;
                    reg_we_o    <= 1'b0;
                    result_o    <= 32'd0;
                    reg_waddr_o <= 5'd0;
                    if (start_i) begin
                        op_r    <= op_i;
                        a_mag_r <= a_mag_s;
                        b_mag_r <= b_mag_s;
                        acc_r   <= acc_init_s;
                        neg_r   <= neg_s;
                        dbz_r   <= dbz_s;
                        waddr_r <= reg_waddr_i;
                        cnt_r   <= 5'd0;
                        busy_o  <= 1'b1;
                        state_r <= to_done_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_step_s;
                    if (cnt_r == LastCount) begin
                        cnt_r   <= 5'd0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + 5'd1;
                        state_r <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    ready_o     <= 1'b1;
                    reg_we_o    <= 1'b1;
                    result_o    <= final_s;
                    reg_waddr_o <= waddr_r;
                    busy_o      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have start_i  in  1  request from ex stage; sampled only in IDLE.
REQ-004 SHALL have op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have reg1_rdata_i  in  32  operand A (rs1) from id_ex.
REQ-006 SHALL have reg2_rdata_i  in  32  operand B (rs2) from id_ex.
REQ-007 SHALL have reg_waddr_i  in  5  destination register.
REQ-008 SHALL have kill_i  in  1  abort, driven by jump or interrupt flush.
REQ-009 SHALL have busy_o  out  1  high while the operation is in flight; ex uses it to raise the pipeline hold.
REQ-010 SHALL have ready_o  out  1  one-cycle result-valid pulse.
REQ-011 SHALL have result_o  out  32  result; zero whenever ready_o is low.
REQ-012 SHALL have reg_we_o  out  1  equals ready_o.
REQ-013 SHALL have reg_waddr_o  out  5  captured destination; zero whenever ready_o is low.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IDLE with start_i=1 and kill_i=0 SHALL latch op, operands and waddr, set busy_o, then go to:
- CALC for the normal case;
- DONE directly for the special cases in REQ-019.
REQ-016 CALC SHALL process one bit per cycle for exactly 32 cycles, counted by a 5-bit counter, then go to DONE.
- Division: restoring shift-subtract on operand magnitudes.
- Multiplication: shift-add into a 64-bit accumulator.
REQ-017 DONE SHALL assert ready_o, reg_we_o and result_o for one cycle, clear busy_o and return to IDLE.
REQ-018 Signed ops SHALL use magnitudes; final sign correction:
- quotient sign = sign(A) XOR sign(B);
- remainder sign = sign(A);
- MULH: both operands signed; MULHSU: A signed, B unsigned;
- result = high 32 bits for MULH, MULHSU, MULHU; low 32 bits for MUL.
REQ-019 Divide-by-zero (B=0) SHALL bypass CALC:
- DIV/DIVU result 0xFFFFFFFF;
- REM/REMU result = A.
REQ-020 Signed overflow (DIV 0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and REM result 0.
REQ-021 start_i SHALL be ignored while not in IDLE.
REQ-022 kill_i=1 in any state SHALL force IDLE on the next edge with no ready_o pulse and busy_o low.
REQ-023 kill_i and start_i high together in IDLE: kill SHALL win.
REQ-024 Nominal latency from start_i to ready_o SHALL be 34 cycles; divide-by-zero latency SHALL be 2 cycles.

Reset
REQ-025 rst low SHALL immediately force:
- state IDLE;
- counter 0;
- busy_o, ready_o, reg_we_o = 0;
- result_o = 0x00000000;
- reg_waddr_o = 0;
- all operand and accumulator registers cleared.
REQ-026 Reset during CALC SHALL discard the operation; no ready_o pulse SHALL follow the release of reset.

Configuration
REQ-027 When MULDIV_FAST_MUL_EN is defined, MUL* ops SHALL compute a combinational 64-bit product, latch it, and go IDLE->DONE with 2-cycle latency.
REQ-028 When MULDIV_FAST_MUL_EN is undefined, MUL* ops SHALL use the iterative 32-cycle CALC path; division is unaffected by the macro in both cases.

Structure
REQ-029 The following constants SHALL live in shared defines.v:
- op encodings (INST_MUL .. INST_REMU);
- FSM state encodings;
- MulDivCycles = 32.
REQ-030 The sign-magnitude conversion and final negation SHALL be one sub-module, muldiv_sign_fix, instantiated for the operand and result paths.
REQ-031 Output registers SHALL be plain flops inside muldiv_unit.

Verification
REQ-032 DIVU 100/7 -> ready_o at cycle 34, result_o 0x0000000E; REMU with the same operands -> 0x00000002.
REQ-033 DIV 0xFFFFFF9C (-100) / 7 -> 0xFFFFFFF2 (-14); REM with the same operands -> 0xFFFFFFFE (-2).
REQ-034 DIV or DIVU with B=0, A=0x12345678 -> result 0xFFFFFFFF at cycle 2; REM -> 0x12345678.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-036 MULH 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE; MUL -> 0x00000001. Run with and without MULDIV_FAST_MUL_EN: latency 2 vs 34.
REQ-037 Abort and reset cases:
- kill_i at CALC cycle 10 -> no ready_o, busy_o low next cycle, a fresh start then completes correctly;
- start_i pulsed mid-CALC -> ignored;
- rst asserted mid-CALC -> all outputs zero.
